// File: rtl/fx2_stream_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : fx2_stream_writer_if
// Description : Bundle of the sample-FIFO read side, the FX2 slave-FIFO write
//               side and the status counters of fx2_stream_writer.
//               master = the writer itself, slave = its surroundings.
// Revision    : 1.0 - initial release
// ============================================================================
interface fx2_stream_writer_if;
    logic        enable;        // streaming enable
    logic [15:0] fifo_dout;     // registered head word of the sample FIFO
    logic        fifo_empty;    // sample FIFO empty flag
    logic        fifo_rd;       // pop strobe towards the sample FIFO
    logic        fx2_full_n;    // FX2 FLAGB, low = endpoint full
    logic [15:0] fx2_fd;        // FX2 data bus
    logic        fx2_slwr_n;    // FX2 write strobe
    logic        fx2_pktend_n;  // FX2 packet-end strobe
    logic [9:0]  word_cnt;      // words in the packet being built
    logic [15:0] pkt_cnt;       // committed packets

    modport master (
        input  enable, fifo_dout, fifo_empty, fx2_full_n,
        output fifo_rd, fx2_fd, fx2_slwr_n, fx2_pktend_n, word_cnt, pkt_cnt
    );

    modport slave (
        output enable, fifo_dout, fifo_empty, fx2_full_n,
        input  fifo_rd, fx2_fd, fx2_slwr_n, fx2_pktend_n, word_cnt, pkt_cnt
    );
endinterface
`default_nettype wire

// File: rtl/fx2_stream_writer.sv
`default_nettype none
// ============================================================================
// Module      : fx2_stream_writer
// Description : Pops 16-bit words from the sample FIFO and writes them into
//               the FX2 synchronous slave FIFO as fixed-size bulk packets.
//               Partial packets are committed with PKTEND after an idle
//               timeout or when streaming is disabled.
// Revision    : 1.0 - initial release
// ============================================================================
module fx2_stream_writer #(
    parameter int PKT_WORDS      = 256,   // words per full packet, power of two
    parameter int TIMEOUT_CYCLES = 4096   // idle cycles before a short packet
) (
    input  wire                 fifo_clk,
    input  wire                 reset_,
    fx2_stream_writer_if.master fx2_io
);

    localparam int              c_IDLE_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [9:0]      c_LAST_WORD = 10'(PKT_WORDS - 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_MAX  = '1;
    localparam logic [c_IDLE_W-1:0] c_IDLE_ONE  = c_IDLE_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_PKTEND = 2'd2
    } state_t;

    state_t              state_q,    state_d;
    logic [15:0]         hold_q,     hold_d;
    logic [9:0]          word_cnt_q, word_cnt_d;
    logic [15:0]         pkt_cnt_q,  pkt_cnt_d;
    logic [c_IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

    logic w_pop_ok;
    logic w_pop;
    logic w_slwr_n;
    logic w_pktend_n;

    // A word may be taken only while streaming is on and the FIFO has data.
    assign w_pop_ok = fx2_io.enable & ~fx2_io.fifo_empty;

    // State, held word and counters; asynchronous clear abandons any partial packet.
    always_ff @(posedge fifo_clk or negedge reset_) begin
        if (!reset_) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            word_cnt_q <= '0;
            pkt_cnt_q  <= '0;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            word_cnt_q <= word_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    // Next-state, pop and FX2 strobe decode.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        word_cnt_d = word_cnt_q;
        pkt_cnt_d  = pkt_cnt_q;
        idle_cnt_d = idle_cnt_q;
        w_pop      = 1'b0;
        w_slwr_n   = 1'b1;
        w_pktend_n = 1'b1;

        case (state_q)
            ST_IDLE: begin
                // Only a packet with data in it can time out.
                if ((word_cnt_q != '0) && (idle_cnt_q != c_IDLE_MAX)) begin
                    idle_cnt_d = idle_cnt_q + c_IDLE_ONE;
                end
                if (w_pop_ok && fx2_io.fx2_full_n) begin
                    w_pop   = 1'b1;
                    hold_d  = fx2_io.fifo_dout;
                    state_d = ST_WRITE;
                end else if ((word_cnt_q != '0) &&
                             (!fx2_io.enable || (idle_cnt_q == c_IDLE_LAST))) begin
                    state_d = ST_PKTEND;
                end
            end

            ST_WRITE: begin
                // The held word goes out even if enable has dropped meanwhile.
                w_slwr_n = ~fx2_io.fx2_full_n;
                if (fx2_io.fx2_full_n) begin
                    idle_cnt_d = '0;
                    if (word_cnt_q == c_LAST_WORD) begin
                        // FX2 commits a full packet on its own; no PKTEND.
                        word_cnt_d = '0;
                        pkt_cnt_d  = pkt_cnt_q + 16'd1;
                        state_d    = ST_IDLE;
                    end else begin
                        word_cnt_d = word_cnt_q + 10'd1;
                        if (w_pop_ok) begin
                            w_pop  = 1'b1;
                            hold_d = fx2_io.fifo_dout;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end

            ST_PKTEND: begin
                w_pktend_n = ~fx2_io.fx2_full_n;
                if (fx2_io.fx2_full_n) begin
                    word_cnt_d = '0;
                    pkt_cnt_d  = pkt_cnt_q + 16'd1;
                    idle_cnt_d = '0;
                    state_d    = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The pop strobe is forced low while reset is held so no word is lost
    // from the sample FIFO without being captured.
    assign fx2_io.fifo_rd      = w_pop & reset_;
    assign fx2_io.fx2_fd       = hold_q;
    assign fx2_io.fx2_slwr_n   = w_slwr_n;
    assign fx2_io.fx2_pktend_n = w_pktend_n;
    assign fx2_io.word_cnt     = word_cnt_q;
    assign fx2_io.pkt_cnt      = pkt_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fx2_stream_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fx2_stream_writer
// Description : Self-checking bench for fx2_stream_writer. A queue models the
//               sample FIFO, a second queue holds the words in push order and
//               the FX2 side is scoreboarded against it, with a packet model
//               (words in packet, committed packets) checking the counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fx2_stream_writer;

    localparam int PKT_WORDS      = 256;
    localparam int TIMEOUT_CYCLES = 4096;

    logic fifo_clk = 1'b0;
    logic reset_   = 1'b0;

    fx2_stream_writer_if bus ();

    fx2_stream_writer #(
        .PKT_WORDS      (PKT_WORDS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_dut (
        .fifo_clk (fifo_clk),
        .reset_   (reset_),
        .fx2_io   (bus)
    );

    always #5 fifo_clk = ~fifo_clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] q_fifo[$];     // contents of the sample FIFO
    logic [15:0] q_stream[$];   // words still owed to the FX2, in push order
    bit          en_r;
    bit          full_r;
    int          m_words;       // words written into the current packet
    logic [15:0] m_pkts;        // committed packets
    int          cyc, n_wr, n_pktend, last_wr_cyc, last_pe_cyc, run, max_run;
    int          wr0, pe0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic push(input logic [15:0] w);
        q_fifo.push_back(w);
        q_stream.push_back(w);
    endtask

    // One clock: drive inputs on the falling edge, observe 1 ns later.
    task automatic step(input bit do_cnt);
        logic [15:0] exp_w;
        @(negedge fifo_clk);
        bus.enable     = en_r;
        bus.fx2_full_n = full_r;
        if (q_fifo.size() != 0) begin
            bus.fifo_dout  = q_fifo[0];
            bus.fifo_empty = 1'b0;
        end else begin
            bus.fifo_dout  = 16'($urandom);
            bus.fifo_empty = 1'b1;
        end
        #1;
        cyc++;
        if (do_cnt) begin
            check_val("word_cnt", 32'(bus.word_cnt), 32'(m_words));
            check_val("pkt_cnt", 32'(bus.pkt_cnt), 32'(m_pkts));
        end
        if (bus.fifo_rd) begin
            check_val("pop_allowed", {30'd0, bus.enable, bus.fifo_empty}, 32'd2);
            if (q_fifo.size() != 0) void'(q_fifo.pop_front());
        end
        if (!bus.fx2_full_n) begin
            check_val("stall_quiet", {30'd0, bus.fx2_slwr_n, bus.fx2_pktend_n}, 32'd3);
        end
        if (!bus.fx2_slwr_n) begin
            check_val("write_has_data", 32'(q_stream.size() != 0), 32'd1);
            if (q_stream.size() != 0) begin
                exp_w = q_stream.pop_front();
                check_val("fd", 32'(bus.fx2_fd), 32'(exp_w));
            end
            n_wr++;
            last_wr_cyc = cyc;
            run++;
            if (run > max_run) max_run = run;
            m_words++;
            if (m_words == PKT_WORDS) begin
                m_words = 0;
                m_pkts++;
            end
        end else begin
            run = 0;
        end
        if (!bus.fx2_pktend_n) begin
            check_val("pktend_guard", {30'd0, bus.fx2_slwr_n, 1'(m_words != 0)}, 32'd3);
            m_words = 0;
            m_pkts++;
            n_pktend++;
            last_pe_cyc = cyc;
        end
    endtask

    initial begin
        bus.enable = 1'b0; bus.fifo_dout = '0; bus.fifo_empty = 1'b1; bus.fx2_full_n = 1'b1;
        en_r = 1'b0; full_r = 1'b1; m_words = 0; m_pkts = '0;
        cyc = 0; n_wr = 0; n_pktend = 0; last_wr_cyc = 0; last_pe_cyc = 0; run = 0; max_run = 0;

        // Reset state
        #2;
        check_val("rst_outputs", {28'd0, bus.fifo_rd, bus.fx2_slwr_n, bus.fx2_pktend_n, 1'b0}, 32'd6);
        check_val("rst_fd", 32'(bus.fx2_fd), 32'd0);
        check_val("rst_word_cnt", 32'(bus.word_cnt), 32'd0);
        check_val("rst_pkt_cnt", 32'(bus.pkt_cnt), 32'd0);
        repeat (3) step(0);
        reset_ = 1'b1;

        // 1: one full packet at full rate, no PKTEND
        for (int i = 0; i < 256; i++) push(16'(i));
        en_r = 1'b1; full_r = 1'b1; run = 0; max_run = 0; wr0 = n_wr;
        for (int i = 0; i < 400 && (n_wr - wr0) < 256; i++) step(0);
        check_val("t1_written", 32'(n_wr - wr0), 32'd256);
        step(0); step(1);
        check_val("t1_burst_len", 32'(max_run), 32'd256);
        check_val("t1_no_pktend", 32'(n_pktend), 32'd0);
        check_val("t1_pkt_cnt", 32'(bus.pkt_cnt), 32'd1);

        // 2: short packet committed after the idle timeout
        for (int i = 0; i < 10; i++) push(16'($urandom));
        wr0 = n_wr; pe0 = n_pktend;
        for (int i = 0; i < TIMEOUT_CYCLES + 300 && n_pktend == pe0; i++) step(0);
        check_val("t2_written", 32'(n_wr - wr0), 32'd10);
        check_val("t2_pktend", 32'(n_pktend - pe0), 32'd1);
        // TIMEOUT_CYCLES idle cycles sit between the last write and PKTEND
        check_val("t2_timeout", 32'(last_pe_cyc - last_wr_cyc), 32'(TIMEOUT_CYCLES + 1));
        repeat (20) step(0);
        step(1);
        check_val("t2_single_pktend", 32'(n_pktend - pe0), 32'd1);

        // 3: stall of 5 cycles at word 100 of a 300-word stream
        for (int i = 0; i < 300; i++) push(16'($urandom));
        wr0 = n_wr;
        begin
            bit stalled = 1'b0;
            for (int i = 0; i < 800 && (n_wr - wr0) < 300; i++) begin
                if (!stalled && (n_wr - wr0) == 100) begin
                    full_r = 1'b0;
                    repeat (5) step(0);
                    full_r  = 1'b1;
                    stalled = 1'b1;
                end
                step(0);
            end
        end
        check_val("t3_written", 32'(n_wr - wr0), 32'd300);
        step(1);
        en_r = 1'b0; pe0 = n_pktend;
        for (int i = 0; i < 50 && n_pktend == pe0; i++) step(0);
        check_val("t3_pktend", 32'(n_pktend - pe0), 32'd1);
        step(1);

        // 4: enable dropped after 40 writes; held word drains, then PKTEND
        for (int i = 0; i < 60; i++) push(16'($urandom));
        en_r = 1'b1; wr0 = n_wr;
        for (int i = 0; i < 200 && (n_wr - wr0) < 40; i++) step(0);
        en_r = 1'b0; pe0 = n_pktend;
        for (int i = 0; i < 50 && n_pktend == pe0; i++) step(0);
        check_val("t4_pktend", 32'(n_pktend - pe0), 32'd1);
        check_val("t4_written", 32'(n_wr - wr0), 32'd41);
        check_val("t4_nothing_held", 32'(q_stream.size()), 32'(q_fifo.size()));
        repeat (5) step(0);
        step(1);
        check_val("t4_fifo_left", 32'(q_fifo.size()), 32'd19);

        // 5: asynchronous reset with 17 words in the packet
        for (int i = 0; i < 40; i++) push(16'($urandom));
        en_r = 1'b1;
        for (int i = 0; i < 200 && m_words != 17; i++) step(0);
        @(negedge fifo_clk);
        #2;
        check_val("t5_mid_packet", 32'(bus.word_cnt), 32'd17);
        reset_ = 1'b0;
        #1;
        check_val("t5_rst_strobes", {28'd0, bus.fifo_rd, bus.fx2_slwr_n, bus.fx2_pktend_n, 1'b0}, 32'd6);
        check_val("t5_rst_fd", 32'(bus.fx2_fd), 32'd0);
        check_val("t5_rst_cnts", {6'd0, bus.word_cnt, bus.pkt_cnt}, 32'd0);
        q_fifo.delete(); q_stream.delete();
        m_words = 0; m_pkts = '0; run = 0; pe0 = n_pktend;
        repeat (3) step(0);
        reset_ = 1'b1; en_r = 1'b0;
        repeat (4) step(0);
        step(1);
        check_val("t5_no_pktend", 32'(n_pktend - pe0), 32'd0);
        for (int i = 0; i < 5; i++) push(16'($urandom));
        en_r = 1'b1; wr0 = n_wr;
        for (int i = 0; i < 50 && (n_wr - wr0) < 5; i++) step(0);
        en_r = 1'b0;
        for (int i = 0; i < 50 && n_pktend == pe0; i++) step(0);
        step(1);
        check_val("t5_restart_pkt", 32'(bus.pkt_cnt), 32'd1);

        // 6: random fill, random FLAGB, occasional enable drops
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(3) == 0 && q_fifo.size() < 500) begin
                repeat ($urandom_range(8, 1)) push(16'($urandom));
            end
            full_r = ($urandom_range(9) > 2);
            en_r   = ($urandom_range(199) != 0);
            step(0);
        end
        en_r = 1'b1; full_r = 1'b1;
        for (int i = 0; i < 2000 && q_stream.size() != 0; i++) step(0);
        en_r = 1'b0;
        for (int i = 0; i < 100 && m_words != 0; i++) step(0);
        step(0);
        step(1);
        check_val("t6_all_written", 32'(q_stream.size()), 32'd0);
        check_val("t6_packet_closed", 32'(m_words), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
